// File: rtl/arm_wb_pkg.sv
// Shared definitions for the LEGv8 register-file writeback front end.
//   REG_W      : register index width
//   DATA_W     : register data width
//   XZR        : index of the zero register; writes to it are discarded
//   wb_entry_t : one pending register write (destination index + value)
package arm_wb_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 64;

    localparam logic [REG_W-1:0] XZR = 5'd31;

    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order buffer of pending register writes.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   push_i        : write push_entry_i at the tail (ignored when full and not popping)
//   push_entry_i  : entry to append
//   pop_i         : remove the head entry (ignored when empty)
//   head_o        : oldest entry
//   count_o       : occupancy, 0..DEPTH
//   rd_ptr_o      : storage slot of the head, used to walk entries by age
//   entries_o     : every storage slot, for the forwarding search
//   valid_o       : per-slot occupied flags
module wb_fifo
    import arm_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  wb_entry_t                push_entry_i,
    input  logic                     pop_i,
    output wb_entry_t                head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [$clog2(DEPTH)-1:0] rd_ptr_o,
    output wb_entry_t                entries_o [DEPTH],
    output logic [DEPTH-1:0]         valid_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    wb_entry_t          mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic [DEPTH-1:0]   valid_q,  valid_d;

    logic push_ok;
    logic pop_ok;

    assign pop_ok  = pop_i && (count_q != '0);
    assign push_ok = push_i && ((count_q != FULL_CNT) || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        // Clear before set: when full, a simultaneous pop and push share a slot
        // and the slot must end up occupied.
        if (pop_ok) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok) begin
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    // Payload storage needs no reset; the valid flags gate every use of it.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_expose
            assign entries_o[gi] = mem_q[gi];
        end
    endgenerate

    assign head_o   = mem_q[rd_ptr_q];
    assign count_o  = count_q;
    assign rd_ptr_o = rd_ptr_q;
    assign valid_o  = valid_q;

endmodule

// File: rtl/regfile_writeback_unit.sv
// Writer-side front end of the 32x64 LEGv8 register file.
// Accepts results from the load path (priority) and the ALU, queues them in
// acceptance order and drains one per cycle onto the single write port.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   alu_valid/alu_ready/alu_rd/alu_data : ALU result handshake
//   mem_valid/mem_ready/mem_rd/mem_data : load result handshake
//   wr_hold                         : write port borrowed, do not drain
//   RdReg1/RdReg2                   : decode read indices (Rn, Rm)
//   fwd1_hit/fwd1_data, fwd2_hit/fwd2_data : youngest pending value per index
//   RdReg3/DataWr/RFWr              : registered register-file write port
//   pending                         : buffer occupancy
module regfile_writeback_unit #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64,
    parameter int REG_W  = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [REG_W-1:0]       alu_rd,
    input  logic [DATA_W-1:0]      alu_data,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [REG_W-1:0]       mem_rd,
    input  logic [DATA_W-1:0]      mem_data,
    input  logic                   wr_hold,
    input  logic [REG_W-1:0]       RdReg1,
    input  logic [REG_W-1:0]       RdReg2,
    output logic                   fwd1_hit,
    output logic [DATA_W-1:0]      fwd1_data,
    output logic                   fwd2_hit,
    output logic [DATA_W-1:0]      fwd2_data,
    output logic [REG_W-1:0]       RdReg3,
    output logic [DATA_W-1:0]      DataWr,
    output logic                   RFWr,
    output logic [$clog2(DEPTH):0] pending
);

    import arm_wb_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    wb_entry_t        head;
    wb_entry_t        entries [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    wb_entry_t push_entry;
    logic      push;
    logic      pop;
    logic      not_full;
    logic      mem_take;
    logic      alu_take;

    logic              rfwr_q,   rfwr_d;
    logic [REG_W-1:0]  rdreg3_q, rdreg3_d;
    logic [DATA_W-1:0] datawr_q, datawr_d;

    // Readiness looks only at registered occupancy, so a full buffer refuses
    // input even in a cycle where it is also draining.
    assign not_full  = (count != FULL_CNT);
    assign mem_ready = not_full;
    assign alu_ready = not_full && !mem_valid;
    assign mem_take  = mem_valid && not_full;
    assign alu_take  = alu_valid && alu_ready;

    // XZR results complete the handshake but never reach the buffer.
    always_comb begin
        push_entry = '{rd: alu_rd, data: alu_data};
        push       = alu_take && (alu_rd != XZR);
        if (mem_take) begin
            push_entry = '{rd: mem_rd, data: mem_data};
            push       = (mem_rd != XZR);
        end
    end

    assign pop = (count != '0) && !wr_hold;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (head),
        .count_o      (count),
        .rd_ptr_o     (rd_ptr),
        .entries_o    (entries),
        .valid_o      (valid)
    );

    // Output stage: the index/data registers keep their last value when idle.
    always_comb begin
        rfwr_d   = pop;
        rdreg3_d = rdreg3_q;
        datawr_d = datawr_q;
        if (pop) begin
            rdreg3_d = head.rd;
            datawr_d = head.data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rfwr_q   <= 1'b0;
            rdreg3_q <= '0;
            datawr_q <= '0;
        end else begin
            rfwr_q   <= rfwr_d;
            rdreg3_q <= rdreg3_d;
            datawr_q <= datawr_d;
        end
    end

    assign RFWr    = rfwr_q;
    assign RdReg3  = rdreg3_q;
    assign DataWr  = datawr_q;
    assign pending = count;

    // Buffer viewed oldest-first: age slot 0 is the head.
    wb_entry_t        age_entry [DEPTH];
    logic [DEPTH-1:0] age_valid;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age_entry[i] = entries[rd_ptr + PTR_W'(i)];
            age_valid[i] = valid[rd_ptr + PTR_W'(i)];
        end
    end

    // Forwarding: scan oldest to youngest so the last match (youngest) wins;
    // the output stage is older than anything still in the buffer.
    logic [REG_W-1:0] fwd_query [2];
    assign fwd_query[0] = RdReg1;
    assign fwd_query[1] = RdReg2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic              hit_c;
            logic [DATA_W-1:0] data_c;

            always_comb begin
                hit_c  = 1'b0;
                data_c = '0;
                if (fwd_query[gi] != XZR) begin
                    if (rfwr_q && (rdreg3_q == fwd_query[gi])) begin
                        hit_c  = 1'b1;
                        data_c = datawr_q;
                    end
                    for (int i = 0; i < DEPTH; i++) begin
                        if (age_valid[i] && (age_entry[i].rd == fwd_query[gi])) begin
                            hit_c  = 1'b1;
                            data_c = age_entry[i].data;
                        end
                    end
                end
            end
        end
    endgenerate

    assign fwd1_hit  = g_fwd[0].hit_c;
    assign fwd1_data = g_fwd[0].data_c;
    assign fwd2_hit  = g_fwd[1].hit_c;
    assign fwd2_data = g_fwd[1].data_c;

endmodule

// File: tb/tb_regfile_writeback_unit.sv
module tb_regfile_writeback_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, mem_valid, wr_hold;
    logic        alu_ready, mem_ready;
    logic [4:0]  alu_rd, mem_rd, RdReg1, RdReg2, RdReg3;
    logic [63:0] alu_data, mem_data, DataWr, fwd1_data, fwd2_data;
    logic        fwd1_hit, fwd2_hit, RFWr;
    logic [2:0]  pending;

    always #5 clk = ~clk;

    regfile_writeback_unit #(.DEPTH(DEPTH), .DATA_W(64), .REG_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .wr_hold   (wr_hold),
        .RdReg1    (RdReg1),
        .RdReg2    (RdReg2),
        .fwd1_hit  (fwd1_hit),
        .fwd1_data (fwd1_data),
        .fwd2_hit  (fwd2_hit),
        .fwd2_data (fwd2_data),
        .RdReg3    (RdReg3),
        .DataWr    (DataWr),
        .RFWr      (RFWr),
        .pending   (pending)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } ent_t;

    ent_t        mq [$];          // pending writes, oldest first
    logic        m_we   = 1'b0;   // write port state
    logic [4:0]  m_rd   = '0;
    logic [63:0] m_data = '0;
    int          m_sz;
    ent_t        wlog [$];        // writes observed on the port

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_we   = 1'b0;
            m_rd   = '0;
            m_data = '0;
        end else begin
            m_sz = mq.size();
            if (m_sz > 0 && !wr_hold) begin
                m_we   = 1'b1;
                m_rd   = mq[0].rd;
                m_data = mq[0].data;
                void'(mq.pop_front());
            end else begin
                m_we = 1'b0;
            end
            if (m_sz < DEPTH) begin
                if (mem_valid) begin
                    if (mem_rd != 5'd31) mq.push_back('{mem_rd, mem_data});
                end else if (alu_valid) begin
                    if (alu_rd != 5'd31) mq.push_back('{alu_rd, alu_data});
                end
            end
        end
    end

    task automatic model_fwd(input logic [4:0] r, output logic hit, output logic [63:0] d);
        hit = 1'b0;
        d   = '0;
        if (r != 5'd31) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].rd == r) begin
                    hit = 1'b1;
                    d   = mq[i].data;
                    break;
                end
            end
            if (!hit && m_we && m_rd == r) begin
                hit = 1'b1;
                d   = m_data;
            end
        end
    endtask

    // Compare process: every cycle, two units after the falling edge.
    initial begin
        logic        h;
        logic [63:0] d;
        forever begin
            @(negedge clk);
            #2;
            chk("pending",   pending,   64'(mq.size()));
            chk("RFWr",      RFWr,      m_we);
            chk("RdReg3",    RdReg3,    m_rd);
            chk("DataWr",    DataWr,    m_data);
            chk("mem_ready", mem_ready, mq.size() < DEPTH);
            chk("alu_ready", alu_ready, (mq.size() < DEPTH) && !mem_valid);
            model_fwd(RdReg1, h, d);
            chk("fwd1_hit",  fwd1_hit,  h);
            chk("fwd1_data", fwd1_data, d);
            model_fwd(RdReg2, h, d);
            chk("fwd2_hit",  fwd2_hit,  h);
            chk("fwd2_data", fwd2_data, d);
            if (RFWr === 1'b1) begin
                $display("[TB] write rd=%0d data=%0h t=%0t", RdReg3, DataWr, $time);
                wlog.push_back('{RdReg3, DataWr});
            end
        end
    end

    // Step to one unit after the next falling edge (input drive point).
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int sent;
        int budget;
        int base;
        rst_n = 1'b0;
        alu_valid = 0; mem_valid = 0; wr_hold = 0;
        alu_rd = 0; mem_rd = 0; alu_data = 0; mem_data = 0;
        RdReg1 = 0; RdReg2 = 0;
        cyc(); cyc();
        #2;
        chk("reset_pending", pending, 0);
        chk("reset_RFWr",    RFWr,    0);
        chk("reset_RdReg3",  RdReg3,  0);
        chk("reset_DataWr",  DataWr,  0);
        rst_n = 1'b1;

        // single ALU write, two-edge latency
        cyc(); alu_valid = 1; alu_rd = 5'd3; alu_data = 64'd1; RdReg1 = 5'd3;
        #2 chk("t1_alu_ready", alu_ready, 1);
        cyc(); alu_valid = 0;
        #2 chk("t1_pending1", pending, 1);
        chk("t1_rfwr_early", RFWr, 0);
        chk("t1_fwd_buf", fwd1_data, 64'd1);
        cyc();
        #2 chk("t1_rfwr", RFWr, 1);
        chk("t1_rdreg3", RdReg3, 3);
        chk("t1_datawr", DataWr, 1);
        chk("t1_pending0", pending, 0);
        cyc();
        #2 chk("t1_rfwr_off", RFWr, 0);

        // memory beats ALU
        cyc(); mem_valid = 1; mem_rd = 5'd5; mem_data = 64'hAA;
        alu_valid = 1; alu_rd = 5'd6; alu_data = 64'hBB;
        #2 chk("t2_alu_blocked", alu_ready, 0);
        chk("t2_mem_ready", mem_ready, 1);
        cyc(); mem_valid = 0;
        #2 chk("t2_alu_ready", alu_ready, 1);
        cyc(); alu_valid = 0;
        #2 chk("t2_first_rd", RdReg3, 5);
        chk("t2_first_data", DataWr, 64'hAA);
        cyc();
        #2 chk("t2_second_rd", RdReg3, 6);
        chk("t2_second_data", DataWr, 64'hBB);

        // hold: buffer fills to DEPTH, then drains in order
        cyc(); cyc();
        base = wlog.size();
        wr_hold = 1;
        sent = 0;
        budget = 0;
        while (sent < 6 && budget < 40) begin
            cyc();
            if (budget == 8) wr_hold = 0;
            alu_valid = 1;
            alu_rd    = 5'(10 + sent);
            alu_data  = 64'(32'h100 + sent);
            #1;
            if (budget == 6) begin
                chk("t3_full_pending", pending, 4);
                chk("t3_full_ready", alu_ready, 0);
                chk("t3_full_memrdy", mem_ready, 0);
            end
            if (alu_ready) sent++;
            budget++;
        end
        chk("t3_all_sent", sent, 6);
        cyc(); alu_valid = 0;
        repeat (8) cyc();
        chk("t3_write_count", wlog.size() - base, 6);
        for (int i = 0; i < 6; i++) begin
            if (base + i < wlog.size()) begin
                chk("t3_order_rd", wlog[base + i].rd, 10 + i);
                chk("t3_order_data", wlog[base + i].data, 32'h100 + i);
            end
        end

        // same register twice: youngest wins
        wr_hold = 1; RdReg1 = 5'd2;
        alu_valid = 1; alu_rd = 5'd2; alu_data = 64'd7;
        cyc(); alu_data = 64'd9;
        cyc(); alu_valid = 0;
        #2 chk("t4_fwd_hit", fwd1_hit, 1);
        chk("t4_fwd_data", fwd1_data, 9);
        cyc(); wr_hold = 0;
        repeat (4) cyc();
        #2 chk("t4_fwd_gone", fwd1_hit, 0);
        chk("t4_fwd_zero", fwd1_data, 0);

        // XZR is dropped, never forwarded
        cyc(); alu_valid = 1; alu_rd = 5'd31; alu_data = 64'hFF; RdReg2 = 5'd31;
        #2 chk("t5_ready", alu_ready, 1);
        chk("t5_fwd2", fwd2_hit, 0);
        cyc(); alu_valid = 0;
        #2 chk("t5_pending", pending, 0);
        repeat (3) begin
            cyc();
            #2 chk("t5_no_write", RFWr, 0);
        end

        // reset discards held entries
        cyc(); wr_hold = 1; alu_valid = 1; RdReg1 = 5'd21;
        for (int i = 0; i < 3; i++) begin
            alu_rd   = 5'(20 + i);
            alu_data = 64'(32'h300 + i);
            cyc();
        end
        alu_valid = 0;
        #2 chk("t6_pending3", pending, 3);
        chk("t6_fwd_hit", fwd1_hit, 1);
        chk("t6_fwd_data", fwd1_data, 64'h301);
        rst_n = 1'b0;
        #1 chk("t6_rst_pending", pending, 0);
        chk("t6_rst_rfwr", RFWr, 0);
        chk("t6_rst_rdreg3", RdReg3, 0);
        chk("t6_rst_datawr", DataWr, 0);
        chk("t6_rst_fwd", fwd1_hit, 0);
        cyc(); rst_n = 1'b1; wr_hold = 0;
        base = wlog.size();
        repeat (5) cyc();
        chk("t6_no_stale", wlog.size(), base);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
